// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind uart_byte_rx: HEADER, CMD, LEN, PAYLOAD[LEN], CHK.
// Buffers the payload, checks length/checksum, enforces an inter-byte timeout.
module uart_rx_frame_ctrl #(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned BAUD         = 9600,
   parameter logic [7:0]  HEADER       = 8'hAA,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_BITS = 20,
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_done,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [7:0]    frame_cmd,
   output logic [7:0]    frame_len,
   output logic          frame_valid,
   output logic          frame_err,
   output logic [1:0]    err_code,
   output logic          busy
);

   localparam int unsigned TIMEOUT_CLKS = (CLK_FREQ / BAUD) * TIMEOUT_BITS;
   localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CMD  = 3'd1;
   localparam logic [2:0] LEN  = 3'd2;
   localparam logic [2:0] DATA = 3'd3;
   localparam logic [2:0] CHK  = 3'd4;

   localparam logic [1:0] ERR_CHK = 2'd1;
   localparam logic [1:0] ERR_LEN = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   logic [2:0]    state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    frame_cmd_q, frame_cmd_d;
   logic [7:0]    frame_len_q, frame_len_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          buf_we;

   logic [7:0] buf_q [2**AW];

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      frame_cmd_d = frame_cmd_q;
      frame_len_d = frame_len_q;
      err_code_d  = err_code_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      buf_we      = 1'b0;
      tmo_d       = (rx_done || state_q == IDLE) ? '0 : tmo_q + 1'b1;

      if (rx_done) begin
         // A byte on the terminal-count cycle is still parsed; the timeout loses.
         case (state_q)
            IDLE: begin
               if (rx_data == HEADER) state_d = CMD;
            end
            CMD: begin
               cmd_d   = rx_data;
               sum_d   = rx_data;
               state_d = LEN;
            end
            LEN: begin
               if (rx_data > MAX_LEN_B) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
                  state_d    = IDLE;
               end else begin
                  len_d   = rx_data;
                  sum_d   = sum_q + rx_data;
                  idx_d   = '0;
                  state_d = (rx_data == 8'd0) ? CHK : DATA;
               end
            end
            DATA: begin
               buf_we = 1'b1;
               sum_d  = sum_q + rx_data;
               idx_d  = idx_q + 8'd1;
               if (idx_q == len_q - 8'd1) state_d = CHK;
            end
            CHK: begin
               if (rx_data == sum_q) begin
                  valid_d     = 1'b1;
                  frame_cmd_d = cmd_q;
                  frame_len_d = len_q;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CHK;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
         err_d      = 1'b1;
         err_code_d = ERR_TMO;
         state_d    = IDLE;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         frame_cmd_q <= '0;
         frame_len_q <= '0;
         err_code_q  <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         frame_cmd_q <= frame_cmd_d;
         frame_len_q <= frame_len_d;
         err_code_q  <= err_code_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   // Payload storage needs no reset; contents are only meaningful after frame_valid.
   always_ff @(posedge sys_clk) begin
      if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_data;
   end

   assign rd_data     = buf_q[rd_addr];
   assign frame_cmd   = frame_cmd_q;
   assign frame_len   = frame_len_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign err_code    = err_code_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frame table plus timeout, max-length and reset sequences.
module tb_uart_rx_frame_ctrl;

   localparam int unsigned CLK_FREQ     = 50_000_000;
   localparam int unsigned BAUD         = 9600;
   localparam int unsigned TIMEOUT_BITS = 2;
   localparam int unsigned MAX_LEN      = 16;
   localparam int unsigned AW           = 4;
   localparam int unsigned TMO          = (CLK_FREQ / BAUD) * TIMEOUT_BITS;  // 10416

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [AW-1:0] rd_addr;
   logic [7:0] rd_data, frame_cmd, frame_len;
   logic       frame_valid, frame_err, busy;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int n_err    = 0;

   uart_rx_frame_ctrl #(
      .CLK_FREQ    (CLK_FREQ),
      .BAUD        (BAUD),
      .HEADER      (8'hAA),
      .MAX_LEN     (MAX_LEN),
      .TIMEOUT_BITS(TIMEOUT_BITS)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .frame_cmd  (frame_cmd),
      .frame_len  (frame_len),
      .frame_valid(frame_valid),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #10 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (frame_valid) n_valid++;
      if (frame_err) n_err++;
      if (frame_valid && frame_err) begin
         n_checks++;
         n_fail++;
         $display("FAIL pulse_exclusive: frame_valid and frame_err both high at %0t", $time);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge sys_clk);
   endtask

   // Returns on the negedge after the sampling posedge, where a deciding pulse is visible.
   task automatic send_byte(input logic [7:0] b);
      @(negedge sys_clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge sys_clk);
      rx_done = 1'b0;
   endtask

   task automatic read_chk(input string name, input int addr, input logic [7:0] exp);
      rd_addr = AW'(addr);
      #1;
      chk(name, {24'd0, rd_data}, {24'd0, exp});
   endtask

   typedef struct {
      int         n;
      logic [7:0] b [8];
      logic       exp_valid;
      logic       exp_err;
      logic [1:0] code;
      logic [7:0] cmd;
      logic [7:0] len;
      logic       chk_rd;
      logic [7:0] rd0;
      logic [7:0] rd1;
   } vec_t;

   vec_t vecs [6];
   logic [7:0] sum;
   int k;

   initial begin
      vecs[0] = '{6, '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33, 8'h00, 8'h00},
                  1'b1, 1'b0, 2'd0, 8'h01, 8'h02, 1'b1, 8'h10, 8'h20};
      vecs[1] = '{6, '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34, 8'h00, 8'h00},
                  1'b0, 1'b1, 2'd1, 8'h01, 8'h02, 1'b0, 8'h00, 8'h00};
      vecs[2] = '{3, '{8'hAA, 8'h07, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b0, 1'b1, 2'd2, 8'h01, 8'h02, 1'b0, 8'h00, 8'h00};
      vecs[3] = '{4, '{8'hAA, 8'h05, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b1, 1'b0, 2'd2, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00};
      vecs[4] = '{8, '{8'h00, 8'h55, 8'hFF, 8'hAA, 8'h03, 8'h01, 8'h7E, 8'h82},
                  1'b1, 1'b0, 2'd2, 8'h03, 8'h01, 1'b1, 8'h7E, 8'h7E};
      vecs[5] = '{6, '{8'hAA, 8'h02, 8'h02, 8'hAA, 8'h01, 8'hAF, 8'h00, 8'h00},
                  1'b1, 1'b0, 2'd2, 8'h02, 8'h02, 1'b1, 8'hAA, 8'h01};

      sys_rst = 1'b1;
      rx_data = 8'h00;
      rx_done = 1'b0;
      rd_addr = '0;
      idle(3);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst_err", {31'd0, frame_err}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_frame_cmd", {24'd0, frame_cmd}, 32'd0);
      chk("rst_frame_len", {24'd0, frame_len}, 32'd0);
      sys_rst = 1'b0;
      idle(2);

      for (int v = 0; v < 6; v++) begin
         n_valid = 0;
         n_err   = 0;
         for (int i = 0; i < vecs[v].n; i++) begin
            send_byte(vecs[v].b[i]);
            if (i != vecs[v].n - 1) idle(2);
         end
         chk($sformatf("v%0d_valid_edge", v), {31'd0, frame_valid}, {31'd0, vecs[v].exp_valid});
         chk($sformatf("v%0d_err_edge", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_err});
         chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
         @(negedge sys_clk);
         chk($sformatf("v%0d_pulse_width", v), {30'd0, frame_valid, frame_err}, 32'd0);
         idle(3);
         chk($sformatf("v%0d_n_valid", v), n_valid, {31'd0, vecs[v].exp_valid});
         chk($sformatf("v%0d_n_err", v), n_err, {31'd0, vecs[v].exp_err});
         chk($sformatf("v%0d_err_code", v), {30'd0, err_code}, {30'd0, vecs[v].code});
         chk($sformatf("v%0d_frame_cmd", v), {24'd0, frame_cmd}, {24'd0, vecs[v].cmd});
         chk($sformatf("v%0d_frame_len", v), {24'd0, frame_len}, {24'd0, vecs[v].len});
         if (vecs[v].chk_rd) begin
            read_chk($sformatf("v%0d_rd0", v), 0, vecs[v].rd0);
            if (vecs[v].len > 8'd1) read_chk($sformatf("v%0d_rd1", v), 1, vecs[v].rd1);
         end
      end

      // Maximum-length payload: LEN == MAX_LEN is accepted.
      n_valid = 0;
      n_err   = 0;
      send_byte(8'hAA);
      send_byte(8'h09);
      send_byte(8'h10);
      sum = 8'h09 + 8'h10;
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i * 3 + 1));
         sum = sum + 8'(i * 3 + 1);
      end
      send_byte(sum);
      chk("maxlen_valid_edge", {31'd0, frame_valid}, 32'd1);
      idle(3);
      chk("maxlen_n_err", n_err, 0);
      chk("maxlen_frame_len", {24'd0, frame_len}, 32'h10);
      chk("maxlen_frame_cmd", {24'd0, frame_cmd}, 32'h09);
      for (int i = 0; i < 16; i++) read_chk($sformatf("maxlen_rd%0d", i), i, 8'(i * 3 + 1));

      // Timeout: error exactly TMO clocks after the last rx_done.
      n_err = 0;
      send_byte(8'hAA);
      send_byte(8'h01);
      k = -1;
      for (int i = 1; i <= TMO + 8; i++) begin
         @(negedge sys_clk);
         if (frame_err) begin
            k = i;
            break;
         end
      end
      chk("tmo_latency", k, TMO);
      chk("tmo_err_code", {30'd0, err_code}, 32'd3);
      chk("tmo_busy", {31'd0, busy}, 32'd0);

      // Byte arriving on the terminal-count cycle wins over the timeout.
      idle(3);
      n_valid = 0;
      n_err   = 0;
      send_byte(8'hAA);
      send_byte(8'h01);
      idle(TMO - 2);
      send_byte(8'h00);
      chk("tmo_edge_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h01);
      chk("tmo_edge_valid", {31'd0, frame_valid}, 32'd1);
      idle(3);
      chk("tmo_edge_n_err", n_err, 0);
      chk("tmo_edge_frame_len", {24'd0, frame_len}, 32'd0);

      // Reset mid-frame aborts with no pulse.
      n_valid = 0;
      n_err   = 0;
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h10);
      chk("midrst_busy_before", {31'd0, busy}, 32'd1);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_frame_cmd", {24'd0, frame_cmd}, 32'd0);
      idle(2);
      sys_rst = 1'b0;
      idle(2);
      chk("midrst_n_pulses", n_valid + n_err, 0);
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h09);
      send_byte(8'h0B);
      chk("midrst_valid_edge", {31'd0, frame_valid}, 32'd1);
      idle(3);
      chk("midrst_n_err", n_err, 0);
      chk("midrst_frame_len", {24'd0, frame_len}, 32'd1);
      read_chk("midrst_rd0", 0, 8'h09);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
